// File: rtl/spi_master_if.sv
// Command/response bus between a local host and spi_master.
// The host drives the master modport; spi_master uses the slave modport.
interface spi_master_if #(
   parameter int WIDTH      = 8,
   parameter int ADDR_WIDTH = 3
);
   logic                  cmd_valid;
   logic                  cmd_ready;
   logic                  cmd_write;
   logic [ADDR_WIDTH-1:0] cmd_addr;
   logic [WIDTH-1:0]      cmd_wdata;
   logic                  rsp_valid;
   logic [7:0]            rsp_status;
   logic [WIDTH-1:0]      rsp_rdata;
   logic                  busy;

   modport master (
      output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
      input  cmd_ready, rsp_valid, rsp_status, rsp_rdata, busy
   );

   modport slave (
      input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
      output cmd_ready, rsp_valid, rsp_status, rsp_rdata, busy
   );
endinterface

// File: rtl/spi_master.sv
// SPI mode-0 initiator: one command byte plus a WIDTH-bit data phase per host command.
// Optional SPI_MASTER_LOOPBACK_EN adds a loopback input that feeds spi_mosi into the receiver.
module spi_master #(
   parameter int WIDTH      = 8,
   parameter int ADDR_WIDTH = 3,
   parameter int CLK_DIV    = 2
) (
   input  logic clk,
   input  logic rstb,
   input  logic ena,
   spi_master_if.slave bus,
   output logic spi_cs_n,
   output logic spi_clk,
   output logic spi_mosi,
`ifdef SPI_MASTER_LOOPBACK_EN
   input  logic loopback,
`endif
   input  logic spi_miso
);
   localparam int FRAME_W = 8 + WIDTH;
   localparam int HP_W    = $clog2(2 * FRAME_W);
   localparam logic [7:0]      DIV_LAST  = 8'(CLK_DIV - 1);
   localparam logic [HP_W-1:0] HP_LAST   = HP_W'(2 * FRAME_W - 1);
   localparam logic [HP_W-1:0] HP_LASTFL = HP_W'(2 * FRAME_W - 2);

   typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

   state_t             state, state_d;
   logic [7:0]         div_cnt;
   logic [HP_W-1:0]    hp_cnt;
   logic [FRAME_W-1:0] tx_sr, rx_sr, frame_d;
   logic [7:0]         cmd_byte, rsp_status_q;
   logic [WIDTH-1:0]   wdata_eff, rsp_rdata_q;
   logic               ph_end, accept, rise, fall, shift_tx, load_rsp, rx_bit;

`ifdef SPI_MASTER_LOOPBACK_EN
   assign rx_bit = loopback ? spi_mosi : spi_miso;
`else
   assign rx_bit = spi_miso;
`endif

   // Reads shift out zeros in the data phase regardless of cmd_wdata.
   always_comb begin
      cmd_byte                   = '0;
      cmd_byte[7]                = bus.cmd_write;
      cmd_byte[ADDR_WIDTH-1:0]   = bus.cmd_addr;
      wdata_eff                  = bus.cmd_write ? bus.cmd_wdata : '0;
      frame_d                    = {cmd_byte, wdata_eff};
   end

   always_comb begin
      state_d  = state;
      accept   = 1'b0;
      rise     = 1'b0;
      fall     = 1'b0;
      shift_tx = 1'b0;
      load_rsp = 1'b0;
      ph_end   = (div_cnt == DIV_LAST);
      case (state)
         IDLE:  if (bus.cmd_valid && ena) begin
                   accept  = 1'b1;
                   state_d = SETUP;
                end
         SETUP: if (ph_end) begin
                   rise    = 1'b1;
                   state_d = SHIFT;
                end
         // Even half-periods have spi_clk high; their end is a falling edge.
         SHIFT: if (ph_end) begin
                   if (!hp_cnt[0]) begin
                      fall     = 1'b1;
                      shift_tx = (hp_cnt != HP_LASTFL);
                   end else if (hp_cnt == HP_LAST) begin
                      state_d = HOLD;
                   end else begin
                      rise = 1'b1;
                   end
                end
         HOLD:  if (ph_end) begin
                   load_rsp = 1'b1;
                   state_d  = GAP;
                end
         GAP:   if (ph_end) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      spi_cs_n       = !(state == SETUP || state == SHIFT || state == HOLD);
      spi_mosi       = !spi_cs_n && tx_sr[FRAME_W-1];
      bus.cmd_ready  = (state == IDLE) && ena;
      bus.busy       = (state != IDLE);
      bus.rsp_valid  = (state == GAP) && (div_cnt == 8'd0);
   end

   assign bus.rsp_status = rsp_status_q;
   assign bus.rsp_rdata  = rsp_rdata_q;

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         state        <= IDLE;
         div_cnt      <= '0;
         hp_cnt       <= '0;
         spi_clk      <= 1'b0;
         rsp_status_q <= '0;
         rsp_rdata_q  <= '0;
      end else begin
         state   <= state_d;
         div_cnt <= (state == IDLE || ph_end) ? 8'd0 : div_cnt + 8'd1;
         if (state != SHIFT)
            hp_cnt <= '0;
         else if (ph_end)
            hp_cnt <= hp_cnt + HP_W'(1);
         if (rise)
            spi_clk <= 1'b1;
         else if (fall)
            spi_clk <= 1'b0;
         if (load_rsp) begin
            rsp_status_q <= rx_sr[FRAME_W-1 -: 8];
            rsp_rdata_q  <= rx_sr[WIDTH-1:0];
         end
      end
   end

   // Shift registers carry data only; cs_n gating keeps spi_mosi clean after reset.
   always_ff @(posedge clk) begin
      if (accept)
         tx_sr <= frame_d;
      else if (shift_tx)
         tx_sr <= {tx_sr[FRAME_W-2:0], 1'b0};
      if (rise)
         rx_sr <= {rx_sr[FRAME_W-2:0], rx_bit};
   end
endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: slave model, bus monitor and a scoreboard of expected frames/responses.
// Build with SPI_MASTER_LOOPBACK_EN to include the loopback step.
module tb_spi_master;
   localparam int WIDTH = 8, ADDR_WIDTH = 3, CLK_DIV = 2;

   logic clk = 1'b0;
   logic rstb, ena;
   logic spi_cs_n, spi_clk, spi_mosi, spi_miso;
`ifdef SPI_MASTER_LOOPBACK_EN
   logic loopback;
`endif

   always #5 clk = ~clk;

   spi_master_if #(.WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) bus ();

   spi_master #(.WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .CLK_DIV(CLK_DIV)) dut (
      .clk      (clk),
      .rstb     (rstb),
      .ena      (ena),
      .bus      (bus),
      .spi_cs_n (spi_cs_n),
      .spi_clk  (spi_clk),
      .spi_mosi (spi_mosi),
`ifdef SPI_MASTER_LOOPBACK_EN
      .loopback (loopback),
`endif
      .spi_miso (spi_miso)
   );

   typedef struct {logic [15:0] frame; logic [7:0] st; logic [7:0] rd;} exp_t;
   typedef struct {logic [15:0] mosi; int rises; int low; logic rv; int gap;} frm_t;
   typedef struct {logic [7:0] st; logic [7:0] rd; int cyc;} rsp_t;

   exp_t exp_q[$];
   frm_t frm_q[$];
   rsp_t rsp_q[$];
   int   acc_q[$];

   // Slave: presents bit 15 when selected, advances on each spi_clk falling edge.
   logic [15:0] sl_pat;
   int          sl_idx;
   bit          sl_act;
   always @(negedge spi_cs_n or posedge spi_cs_n or negedge spi_clk) begin
      if (spi_cs_n) begin
         sl_act   = 1'b0;
         spi_miso = 1'b0;
      end else begin
         if (!sl_act) begin
            sl_act = 1'b1;
            sl_idx = 0;
         end else begin
            sl_idx++;
         end
         spi_miso = (sl_idx < 16) ? sl_pat[15-sl_idx] : 1'b0;
      end
   end

   int          rise_cnt = 0;
   logic [15:0] mosi_cap;
   always @(posedge spi_clk or negedge spi_cs_n) begin
      if (!spi_cs_n && !spi_clk) begin
         rise_cnt = 0;
         mosi_cap = '0;
      end else if (spi_clk && !spi_cs_n) begin
         rise_cnt++;
         mosi_cap = {mosi_cap[14:0], spi_mosi};
      end
   end

   int   cyc = 0, low_cnt = 0, high_cnt = 0, start_gap = 0, mosi_bad = 0, rdy_rise = 0;
   bit   in_frame = 1'b0;
   logic prev_rdy = 1'b0;
   always @(negedge clk) begin
      cyc++;
      if (rstb && bus.cmd_valid && bus.cmd_ready) acc_q.push_back(cyc);
      if (rstb && bus.rsp_valid) rsp_q.push_back(rsp_t'{bus.rsp_status, bus.rsp_rdata, cyc});
      if (bus.cmd_ready && !prev_rdy) rdy_rise = cyc;
      prev_rdy = bus.cmd_ready;
      if (spi_cs_n && spi_mosi) mosi_bad++;
      if (!rstb) begin
         in_frame = 1'b0;
         high_cnt = 0;
      end else if (!spi_cs_n) begin
         if (!in_frame) begin
            in_frame  = 1'b1;
            low_cnt   = 0;
            start_gap = high_cnt;
         end
         low_cnt++;
      end else begin
         if (in_frame) begin
            frm_q.push_back(frm_t'{mosi_cap, rise_cnt, low_cnt, bus.rsp_valid, start_gap});
            in_frame = 1'b0;
            high_cnt = 0;
         end
         high_cnt++;
      end
   end

   int n_tests = 0, n_fail = 0;
   int frm_i = 0, rsp_i = 0, acc_i = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic send(input bit wr, input logic [2:0] addr, input logic [7:0] wd,
                       input bit keep, input logic [7:0] est, input logic [7:0] erd);
      int n0;
      bit ok;
      @(posedge clk); #1;
      bus.cmd_valid = 1'b1;
      bus.cmd_write = wr;
      bus.cmd_addr  = addr;
      bus.cmd_wdata = wd;
      exp_q.push_back(exp_t'{{wr, 4'b0000, addr, (wr ? wd : 8'h00)}, est, erd});
      n0 = acc_q.size();
      ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(posedge clk); #1;
         if (acc_q.size() > n0) begin
            ok = 1'b1;
            break;
         end
      end
      check("accept", ok, 1);
      check("busy_after_accept", bus.busy, 1);
      if (!keep) bus.cmd_valid = 1'b0;
   endtask

   task automatic wait_rsp(input int n);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         @(posedge clk); #1;
         if (rsp_q.size() >= n) begin
            ok = 1'b1;
            break;
         end
      end
      check("rsp_arrived", ok, 1);
   endtask

   task automatic score();
      exp_t e;
      frm_t f;
      rsp_t r;
      int   a;
      while (exp_q.size() > 0 && frm_i < frm_q.size() && rsp_i < rsp_q.size() && acc_i < acc_q.size()) begin
         e = exp_q.pop_front();
         f = frm_q[frm_i];
         r = rsp_q[rsp_i];
         a = acc_q[acc_i];
         frm_i++; rsp_i++; acc_i++;
         check("mosi_frame", f.mosi, e.frame);
         check("spi_clk_rises", f.rises, 16);
         check("cs_low_cycles", f.low, 68);
         check("rsp_at_cs_rise", f.rv, 1);
         check("rsp_status", r.st, e.st);
         check("rsp_rdata", r.rd, e.rd);
         check("rsp_latency", r.cyc - a, 69);
      end
      check("unmatched_expect", exp_q.size(), 0);
   endtask

   initial begin
      int base, n_acc;
      bus.cmd_valid = 1'b0;
      bus.cmd_write = 1'b0;
      bus.cmd_addr  = '0;
      bus.cmd_wdata = '0;
      rstb   = 1'b0;
      ena    = 1'b0;
      sl_pat = 16'h0000;
`ifdef SPI_MASTER_LOOPBACK_EN
      loopback = 1'b0;
`endif
      repeat (3) @(posedge clk); #1;
      check("rst_cs_n", spi_cs_n, 1);
      check("rst_spi_clk", spi_clk, 0);
      check("rst_mosi", spi_mosi, 0);
      check("rst_cmd_ready", bus.cmd_ready, 0);
      check("rst_rsp_valid", bus.rsp_valid, 0);
      check("rst_rsp_status", bus.rsp_status, 0);
      check("rst_rsp_rdata", bus.rsp_rdata, 0);
      check("rst_busy", bus.busy, 0);
      rstb = 1'b1;
      ena  = 1'b1;
      @(posedge clk); #1;
      check("idle_ready", bus.cmd_ready, 1);

      // Write addr 2, data 0x5A
      sl_pat = 16'h7E81;
      send(1'b1, 3'd2, 8'h5A, 1'b0, 8'h7E, 8'h81);
      wait_rsp(1);
      repeat (5) @(posedge clk); #1;
      check("ready_after_rsp", rdy_rise - rsp_q[0].cyc, 2);
      score();

      // Read addr 6; wdata must not appear on MOSI
      sl_pat = 16'h01C3;
      send(1'b0, 3'd6, 8'hFF, 1'b0, 8'h01, 8'hC3);
      wait_rsp(2);
      score();

      // Back-to-back writes with cmd_valid held high
      sl_pat = 16'h3CA5;
      base = frm_q.size();
      send(1'b1, 3'd1, 8'h01, 1'b1, 8'h3C, 8'hA5);
      send(1'b1, 3'd3, 8'h11, 1'b1, 8'h3C, 8'hA5);
      send(1'b1, 3'd4, 8'h2A, 1'b0, 8'h3C, 8'hA5);
      wait_rsp(5);
      check("b2b_gap_1", frm_q[base+1].gap, 3);
      check("b2b_gap_2", frm_q[base+2].gap, 3);
      score();

      // Reset at the fifth spi_clk rising edge
      sl_pat = 16'h5555;
      send(1'b1, 3'd7, 8'hC6, 1'b0, 8'h55, 8'h55);
      for (int i = 0; i < 200; i++) begin
         @(posedge clk); #1;
         if (rise_cnt >= 5) break;
      end
      check("abort_at_edge5", rise_cnt, 5);
      rstb = 1'b0;
      #1;
      check("abort_cs_n", spi_cs_n, 1);
      check("abort_spi_clk", spi_clk, 0);
      check("abort_mosi", spi_mosi, 0);
      check("abort_busy", bus.busy, 0);
      check("abort_status", bus.rsp_status, 0);
      void'(exp_q.pop_back());
      repeat (3) @(posedge clk); #1;
      acc_i = acc_q.size();
      rstb = 1'b1;
      repeat (100) @(posedge clk); #1;
      check("abort_no_rsp", rsp_q.size(), 5);
      check("abort_no_frame", frm_q.size(), 5);

      sl_pat = 16'hA0F1;
      send(1'b1, 3'd0, 8'hE7, 1'b0, 8'hA0, 8'hF1);
      wait_rsp(6);
      score();

      // ena low blocks acceptance
      ena = 1'b0;
      bus.cmd_valid = 1'b1;
      bus.cmd_write = 1'b1;
      bus.cmd_addr  = 3'd3;
      bus.cmd_wdata = 8'h77;
      n_acc = acc_q.size();
      repeat (20) @(posedge clk); #1;
      check("ena_low_ready", bus.cmd_ready, 0);
      check("ena_low_no_accept", acc_q.size(), n_acc);
      check("ena_low_cs_n", spi_cs_n, 1);
      bus.cmd_valid = 1'b0;

      // ena dropped mid-frame: frame completes, nothing further accepted
      ena = 1'b1;
      sl_pat = 16'h9F06;
      send(1'b1, 3'd5, 8'h42, 1'b1, 8'h9F, 8'h06);
      repeat (10) @(posedge clk); #1;
      ena = 1'b0;
      wait_rsp(7);
      repeat (30) @(posedge clk); #1;
      check("ena_drop_ready", bus.cmd_ready, 0);
      check("ena_drop_one_accept", acc_q.size(), n_acc + 1);
      check("ena_drop_idle", bus.busy, 0);
      bus.cmd_valid = 1'b0;
      score();
      ena = 1'b1;

`ifdef SPI_MASTER_LOOPBACK_EN
      loopback = 1'b1;
      sl_pat = 16'hFFFF;
      send(1'b1, 3'd5, 8'h3C, 1'b0, 8'h85, 8'h3C);
      wait_rsp(8);
      score();
      loopback = 1'b0;
`endif

      check("mosi_low_when_deselected", mosi_bad, 0);
      check("frames_vs_rsps", frm_q.size(), rsp_q.size());
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
